cache_ctrl_2way: RTL and testbench

Controller and line store for the 2-way set-associative, write-back, write-allocate data cache: 4 sets × 2 ways of 8-bit data with 8-bit tags. It accepts one CPU read/write request at a time and resolves hit or miss against both ways. On a miss it selects a victim by valid/LRU state, writes back a dirty victim, and refills over a single-beat memory handshake. It sits between the CPU load/store port and the backing memory model.

---
 rtl/cache_ctrl_2way.sv | 150 +++++++++++++++
 tb/tb_cache_ctrl_2way.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_2way.sv
// 2-way set-associative write-back/write-allocate data cache: 4 sets x 2 ways, 8-bit tag/data.
// Hit responds two edges after acceptance; misses add write-back/refill cycles per mem_ack.
module cache_ctrl_2way (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [1:0] req_index,
   input  logic [7:0] req_tag,
   input  logic [7:0] req_wdata,
   output logic       resp_valid,
   output logic       resp_hit,
   output logic [7:0] resp_rdata,
   output logic       mem_req,
   output logic       mem_we,
   output logic [9:0] mem_addr,
   output logic [7:0] mem_wdata,
   input  logic       mem_ack,
   input  logic [7:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;

   state_t     state, state_nx;
   logic       lat_write;
   logic [1:0] lat_index;
   logic [7:0] lat_tag, lat_wdata;
   logic       victim;

   // Entry {way, index}: way 0 of set i is entry i, way 1 is entry i+4.
   logic [7:0] line_valid, line_dirty;
   logic [7:0] line_tag  [8];
   logic [7:0] line_data [8];
   logic [3:0] lru;

   logic [2:0] e0, e1, hit_e, miss_e, vic_e;
   logic       hit0, hit1, hit, hit_way, miss_way, miss_wb;

   always_comb begin
      e0       = {1'b0, lat_index};
      e1       = {1'b1, lat_index};
      hit0     = line_valid[e0] && (line_tag[e0] == lat_tag);
      hit1     = line_valid[e1] && (line_tag[e1] == lat_tag);
      hit      = hit0 | hit1;
      hit_way  = hit1;
      if (!line_valid[e0])      miss_way = 1'b0;
      else if (!line_valid[e1]) miss_way = 1'b1;
      else                      miss_way = lru[lat_index];
      hit_e    = {hit_way, lat_index};
      miss_e   = {miss_way, lat_index};
      vic_e    = {victim, lat_index};
      miss_wb  = line_valid[miss_e] & line_dirty[miss_e];
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (req_valid) state_nx = LOOKUP;
         LOOKUP:    if (hit)           state_nx = RESPOND;
                    else if (miss_wb)  state_nx = WRITEBACK;
                    else               state_nx = REFILL;
         WRITEBACK: if (mem_ack) state_nx = REFILL;
         REFILL:    if (mem_ack) state_nx = RESPOND;
         RESPOND:   state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   assign req_ready = (state == IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lat_write  <= 1'b0;
         lat_index  <= '0;
         lat_tag    <= '0;
         lat_wdata  <= '0;
         victim     <= 1'b0;
         line_valid <= '0;
         line_dirty <= '0;
         lru        <= '0;
         for (int i = 0; i < 8; i++) begin
            line_tag[i]  <= '0;
            line_data[i] <= '0;
         end
         resp_valid <= 1'b0;
         resp_hit   <= 1'b0;
         resp_rdata <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: if (req_valid) begin
               lat_write <= req_write;
               lat_index <= req_index;
               lat_tag   <= req_tag;
               lat_wdata <= req_wdata;
            end
            LOOKUP: if (hit) begin
               if (lat_write) begin
                  line_data[hit_e]  <= lat_wdata;
                  line_dirty[hit_e] <= 1'b1;
                  resp_rdata        <= lat_wdata;
               end else begin
                  resp_rdata        <= line_data[hit_e];
               end
               resp_hit       <= 1'b1;
               lru[lat_index] <= ~hit_way;
            end else begin
               victim  <= miss_way;
               mem_req <= 1'b1;
               if (miss_wb) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= {line_tag[miss_e], lat_index};
                  mem_wdata <= line_data[miss_e];
               end else begin
                  mem_we    <= 1'b0;
                  mem_addr  <= {lat_tag, lat_index};
               end
            end
            // mem_req stays high into the refill; only direction and address move.
            WRITEBACK: if (mem_ack) begin
               mem_we   <= 1'b0;
               mem_addr <= {lat_tag, lat_index};
            end
            REFILL: if (mem_ack) begin
               mem_req           <= 1'b0;
               line_valid[vic_e] <= 1'b1;
               line_dirty[vic_e] <= lat_write;
               line_tag[vic_e]   <= lat_tag;
               line_data[vic_e]  <= lat_write ? lat_wdata : mem_rdata;
               resp_rdata        <= lat_write ? lat_wdata : mem_rdata;
               resp_hit          <= 1'b0;
               lru[lat_index]    <= ~victim;
            end
            RESPOND: resp_valid <= 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Self-checking bench for cache_ctrl_2way: directed vector table, reset corner cases,
// then random traffic against a recency-ordered per-set model with a memory-truth array.
module tb_cache_ctrl_2way;

   logic       clock = 1'b0;
   logic       reset;
   logic       req_valid, req_ready, req_write;
   logic [1:0] req_index;
   logic [7:0] req_tag, req_wdata;
   logic       resp_valid, resp_hit;
   logic [7:0] resp_rdata;
   logic       mem_req, mem_we, mem_ack;
   logic [9:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata;

   cache_ctrl_2way dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_index(req_index), .req_tag(req_tag), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_rdata(resp_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [7:0] bmem  [1024];   // backing memory as the DUT sees it
   logic [7:0] truth [1024];   // architecturally visible value per address

   typedef struct {
      bit [7:0] tag;
      bit       dirty;
   } mline_t;
   mline_t setq [4][$];        // per set, most recently used first

   typedef struct {
      bit       w;
      bit [1:0] idx;
      bit [7:0] tag;
      bit [7:0] wd;
      int       dly;
      bit       poke;
      bit       hit;
      bit [7:0] rd;
      int       lat;
      bit       wb;
      bit [9:0] wba;
      bit [7:0] wbd;
      bit       rf;
      bit [9:0] rfa;
   } vec_t;
   vec_t vt [10];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 4; s++) setq[s].delete();
      for (int a = 0; a < 1024; a++) truth[a] = bmem[a];
   endtask

   task automatic predict(input bit w, input bit [1:0] idx, input bit [7:0] tg, input bit [7:0] wd,
                          input int dly, output bit e_hit, output bit [7:0] e_rd, output int e_lat,
                          output bit e_wb, output bit [9:0] e_wba, output bit [7:0] e_wbd,
                          output bit e_rf, output bit [9:0] e_rfa);
      bit [9:0] addr;
      int       pos;
      mline_t   ln;
      addr  = {tg, idx};
      pos   = -1;
      e_wb  = 0; e_wba = 0; e_wbd = 0;
      e_rf  = 0; e_rfa = 0;
      foreach (setq[idx][i]) if (setq[idx][i].tag == tg) pos = i;
      if (pos >= 0) begin
         ln = setq[idx][pos];
         setq[idx].delete(pos);
         if (w) ln.dirty = 1;
         setq[idx].push_front(ln);
         e_hit = 1;
         e_lat = 2;
      end else begin
         e_hit = 0;
         e_rf  = 1;
         e_rfa = addr;
         if (setq[idx].size() == 2) begin
            ln = setq[idx].pop_back();
            if (ln.dirty) begin
               e_wb  = 1;
               e_wba = {ln.tag, idx};
               e_wbd = truth[e_wba];
            end
         end
         ln.tag = tg; ln.dirty = w;
         setq[idx].push_front(ln);
         e_lat = 3 + dly + (e_wb ? 1 + dly : 0);
      end
      if (w) truth[addr] = wd;
      e_rd = truth[addr];
   endtask

   // Issues one request at a negedge, plays the memory, checks response and memory traffic.
   task automatic run_req(input bit w, input bit [1:0] idx, input bit [7:0] tg, input bit [7:0] wd,
                          input int dly, input bit poke, input bit e_hit, input bit [7:0] e_rd,
                          input int e_lat, input bit e_wb, input bit [9:0] e_wba, input bit [7:0] e_wbd,
                          input bit e_rf, input bit [9:0] e_rfa);
      bit       got = 0, new_txn = 1, acked = 0, unstable = 0, busy_bad = 0;
      int       waitc = 0, ntx = 0, lat = -1;
      bit       hit = 0;
      bit [7:0] rd = 0;
      bit [9:0] tx_addr [2];
      bit       tx_we   [2];
      bit [7:0] tx_wd   [2];
      bit [9:0] cur_addr = 0;
      bit       cur_we = 0;
      bit [7:0] cur_wd = 0;
      req_valid = 1; req_write = w; req_index = idx; req_tag = tg; req_wdata = wd;
      for (int k = 0; k < 60 && !got; k++) begin
         @(negedge clock);
         mem_ack = 0;
         if (k == 0) req_valid = 0;
         if (poke && k == 3) begin
            req_valid = 1; req_write = 1; req_tag = ~tg; req_wdata = 8'hEE;
         end
         if (poke && k == 4) req_valid = 0;
         if (resp_valid) begin
            got = 1; lat = k; hit = resp_hit; rd = resp_rdata;
         end else begin
            if (req_ready) busy_bad = 1;
            if (acked) begin acked = 0; new_txn = 1; waitc = 0; end
            if (mem_req) begin
               if (new_txn) begin
                  new_txn = 0;
                  if (ntx < 2) begin
                     tx_addr[ntx] = mem_addr; tx_we[ntx] = mem_we; tx_wd[ntx] = mem_wdata;
                  end
                  ntx++;
                  cur_addr = mem_addr; cur_we = mem_we; cur_wd = mem_wdata;
               end else if (mem_addr != cur_addr || mem_we != cur_we ||
                            (cur_we && mem_wdata != cur_wd)) begin
                  unstable = 1;
               end
               if (waitc == dly) begin
                  mem_ack   = 1;
                  mem_rdata = bmem[mem_addr];
                  if (mem_we) bmem[mem_addr] = mem_wdata;
                  acked = 1;
               end else begin
                  waitc++;
               end
            end
         end
      end
      chk("resp_seen", int'(got), 1);
      if (got) begin
         chk("resp_hit", int'(hit), int'(e_hit));
         chk("resp_rdata", int'(rd), int'(e_rd));
         chk("latency", lat, e_lat);
      end
      chk("mem_txn_count", ntx, int'(e_wb) + int'(e_rf));
      if (e_wb && ntx >= 1) begin
         chk("wb_we", int'(tx_we[0]), 1);
         chk("wb_addr", int'(tx_addr[0]), int'(e_wba));
         chk("wb_data", int'(tx_wd[0]), int'(e_wbd));
      end
      if (e_rf && ntx >= int'(e_wb) + 1) begin
         chk("rf_we", int'(tx_we[int'(e_wb)]), 0);
         chk("rf_addr", int'(tx_addr[int'(e_wb)]), int'(e_rfa));
      end
      chk("mem_stable", int'(unstable), 0);
      chk("busy_not_ready", int'(busy_bad), 0);
      @(negedge clock);
      chk("resp_single_pulse", int'(resp_valid), 0);
   endtask

   bit       p_hit, p_wb, p_rf, rw;
   bit [7:0] p_rd, p_wbd, rtag, rwd;
   bit [9:0] p_wba, p_rfa;
   bit [1:0] ridx;
   int       p_lat, rdly;

   initial begin
      reset = 1; req_valid = 0; req_write = 0; req_index = 0; req_tag = 0; req_wdata = 0;
      mem_ack = 0; mem_rdata = 0;
      for (int a = 0; a < 1024; a++) bmem[a] = 8'($urandom);
      bmem[10'h0E9] = 8'h5C; bmem[10'h041] = 8'hA1; bmem[10'h089] = 8'hB2;
      bmem[10'h155] = 8'hC3; bmem[10'h112] = 8'hD4;
      model_reset();

      //          w  idx   tag    wd     dly p  hit  rd     lat wb wba      wbd    rf rfa
      vt[0] = '{0, 2'd1, 8'h3A, 8'h00, 0, 0, 1'b0, 8'h5C, 3, 0, 10'h000, 8'h00, 1, 10'h0E9};
      vt[1] = '{0, 2'd1, 8'h3A, 8'h00, 0, 0, 1'b1, 8'h5C, 2, 0, 10'h000, 8'h00, 0, 10'h000};
      vt[2] = '{1, 2'd1, 8'h3A, 8'h77, 0, 0, 1'b1, 8'h77, 2, 0, 10'h000, 8'h00, 0, 10'h000};
      vt[3] = '{0, 2'd1, 8'h3A, 8'h00, 0, 0, 1'b1, 8'h77, 2, 0, 10'h000, 8'h00, 0, 10'h000};
      vt[4] = '{0, 2'd1, 8'h10, 8'h00, 0, 0, 1'b0, 8'hA1, 3, 0, 10'h000, 8'h00, 1, 10'h041};
      vt[5] = '{0, 2'd1, 8'h22, 8'h00, 0, 0, 1'b0, 8'hB2, 4, 1, 10'h0E9, 8'h77, 1, 10'h089};
      vt[6] = '{0, 2'd1, 8'h10, 8'h00, 0, 0, 1'b1, 8'hA1, 2, 0, 10'h000, 8'h00, 0, 10'h000};
      vt[7] = '{0, 2'd1, 8'h55, 8'h00, 0, 0, 1'b0, 8'hC3, 3, 0, 10'h000, 8'h00, 1, 10'h155};
      vt[8] = '{0, 2'd1, 8'h10, 8'h00, 0, 0, 1'b1, 8'hA1, 2, 0, 10'h000, 8'h00, 0, 10'h000};
      vt[9] = '{0, 2'd2, 8'h44, 8'h00, 5, 1, 1'b0, 8'hD4, 8, 0, 10'h000, 8'h00, 1, 10'h112};

      @(negedge clock);
      @(negedge clock);
      reset = 0;
      chk("rst_req_ready", int'(req_ready), 1);
      chk("rst_resp_valid", int'(resp_valid), 0);
      chk("rst_resp_hit", int'(resp_hit), 0);
      chk("rst_resp_rdata", int'(resp_rdata), 0);
      chk("rst_mem_req", int'(mem_req), 0);
      chk("rst_mem_we", int'(mem_we), 0);
      chk("rst_mem_addr", int'(mem_addr), 0);
      chk("rst_mem_wdata", int'(mem_wdata), 0);

      for (int i = 0; i < 10; i++) begin
         predict(vt[i].w, vt[i].idx, vt[i].tag, vt[i].wd, vt[i].dly,
                 p_hit, p_rd, p_lat, p_wb, p_wba, p_wbd, p_rf, p_rfa);
         run_req(vt[i].w, vt[i].idx, vt[i].tag, vt[i].wd, vt[i].dly, vt[i].poke,
                 vt[i].hit, vt[i].rd, vt[i].lat, vt[i].wb, vt[i].wba, vt[i].wbd, vt[i].rf, vt[i].rfa);
      end

      // Reset while the refill for index 3, tag 0x99 is outstanding.
      req_valid = 1; req_write = 0; req_index = 2'd3; req_tag = 8'h99; req_wdata = 0;
      @(negedge clock);
      req_valid = 0;
      @(negedge clock);
      chk("midrf_mem_req", int'(mem_req), 1);
      chk("midrf_mem_addr", int'(mem_addr), 10'h267);
      #2 reset = 1;
      #1;
      chk("midrf_async_mem_req", int'(mem_req), 0);
      chk("midrf_async_ready", int'(req_ready), 1);
      @(negedge clock);
      reset = 0; mem_ack = 1; mem_rdata = 8'h5A;
      @(negedge clock);
      mem_ack = 0;
      chk("midrf_no_resp", int'(resp_valid), 0);
      chk("midrf_mem_req_idle", int'(mem_req), 0);
      chk("midrf_ready", int'(req_ready), 1);
      model_reset();
      predict(0, 2'd3, 8'h99, 8'h00, 0, p_hit, p_rd, p_lat, p_wb, p_wba, p_wbd, p_rf, p_rfa);
      run_req(0, 2'd3, 8'h99, 8'h00, 0, 0, p_hit, p_rd, p_lat, p_wb, p_wba, p_wbd, p_rf, p_rfa);

      for (int n = 0; n < 200; n++) begin
         rw   = 1'($urandom_range(0, 1));
         ridx = 2'($urandom_range(0, 3));
         rtag = 8'h80 + 8'($urandom_range(0, 2));
         rwd  = 8'($urandom);
         rdly = int'($urandom_range(0, 2));
         predict(rw, ridx, rtag, rwd, rdly, p_hit, p_rd, p_lat, p_wb, p_wba, p_wbd, p_rf, p_rfa);
         run_req(rw, ridx, rtag, rwd, rdly, 0, p_hit, p_rd, p_lat, p_wb, p_wba, p_wbd, p_rf, p_rfa);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
